// File: rtl/reorder_buffer_if.sv
// Dispatch / completion / retirement bundle of the reorder buffer.
// The master modport is the pipeline side; the slave modport is the ROB.
interface reorder_buffer_if #(
   parameter int ROB_SIZE = 64
);
   localparam int IDX_W = $clog2(ROB_SIZE);

   logic              alloc_valid;
   logic              alloc_ready;
   logic [4:0]        alloc_arch_rd;
   logic [5:0]        alloc_phys_rd;
   logic [5:0]        alloc_old_phys_rd;
   logic              alloc_reg_write;
   logic [IDX_W-1:0]  alloc_rob_num;

   logic              complete_valid_0, complete_valid_1, complete_valid_2;
   logic [IDX_W-1:0]  complete_rob_0, complete_rob_1, complete_rob_2;
   logic [31:0]       complete_value_0, complete_value_1, complete_value_2;

   logic              retire_valid_0, retire_valid_1;
   logic [4:0]        retire_arch_rd_0, retire_arch_rd_1;
   logic [5:0]        retire_phys_rd_0, retire_phys_rd_1;
   logic [5:0]        retire_old_phys_rd_0, retire_old_phys_rd_1;
   logic              retire_reg_write_0, retire_reg_write_1;
   logic [31:0]       retire_value_0, retire_value_1;

   logic [IDX_W:0]    rob_count;

   modport master (
      output alloc_valid, alloc_arch_rd, alloc_phys_rd, alloc_old_phys_rd, alloc_reg_write,
      output complete_valid_0, complete_valid_1, complete_valid_2,
      output complete_rob_0, complete_rob_1, complete_rob_2,
      output complete_value_0, complete_value_1, complete_value_2,
      input  alloc_ready, alloc_rob_num, rob_count,
      input  retire_valid_0, retire_valid_1, retire_arch_rd_0, retire_arch_rd_1,
      input  retire_phys_rd_0, retire_phys_rd_1, retire_old_phys_rd_0, retire_old_phys_rd_1,
      input  retire_reg_write_0, retire_reg_write_1, retire_value_0, retire_value_1
   );

   modport slave (
      input  alloc_valid, alloc_arch_rd, alloc_phys_rd, alloc_old_phys_rd, alloc_reg_write,
      input  complete_valid_0, complete_valid_1, complete_valid_2,
      input  complete_rob_0, complete_rob_1, complete_rob_2,
      input  complete_value_0, complete_value_1, complete_value_2,
      output alloc_ready, alloc_rob_num, rob_count,
      output retire_valid_0, retire_valid_1, retire_arch_rd_0, retire_arch_rd_1,
      output retire_phys_rd_0, retire_phys_rd_1, retire_old_phys_rd_0, retire_old_phys_rd_1,
      output retire_reg_write_0, retire_reg_write_1, retire_value_0, retire_value_1
   );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order complete, up to two in-order retires per cycle.
// Define ROB_FLUSH_EN to add the synchronous flush input.
module reorder_buffer #(
   parameter int ROB_SIZE     = 64,
   parameter int RETIRE_WIDTH = 2
) (
   input logic             clk,
   input logic             reset,
`ifdef ROB_FLUSH_EN
   input logic             flush,
`endif
   reorder_buffer_if.slave rob
);
   localparam int IDX_W = $clog2(ROB_SIZE);
   localparam int CNT_W = IDX_W + 1;
   localparam int RET_W = $clog2(RETIRE_WIDTH + 1);
   localparam int NCMP  = 3;

   logic [ROB_SIZE-1:0] valid_q, valid_d, complete_q, complete_d;
   logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d, head1;
   logic [CNT_W-1:0]    count_q, count_d;

   logic                reg_write_q   [ROB_SIZE];
   logic [4:0]          arch_rd_q     [ROB_SIZE];
   logic [5:0]          phys_rd_q     [ROB_SIZE];
   logic [5:0]          old_phys_rd_q [ROB_SIZE];
   logic [31:0]         value_q       [ROB_SIZE];

   logic                cmp_vld [NCMP];
   logic [IDX_W-1:0]    cmp_idx [NCMP];
   logic [31:0]         cmp_val [NCMP];

   logic                flush_w, alloc_ready, alloc_fire, ret0, ret1;
   logic [RET_W-1:0]    n_ret;

`ifdef ROB_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   assign cmp_vld[0] = rob.complete_valid_0;
   assign cmp_vld[1] = rob.complete_valid_1;
   assign cmp_vld[2] = rob.complete_valid_2;
   assign cmp_idx[0] = rob.complete_rob_0;
   assign cmp_idx[1] = rob.complete_rob_1;
   assign cmp_idx[2] = rob.complete_rob_2;
   assign cmp_val[0] = rob.complete_value_0;
   assign cmp_val[1] = rob.complete_value_1;
   assign cmp_val[2] = rob.complete_value_2;

   // Space freed by a retirement only becomes visible once count_q updates.
   assign alloc_ready = !flush_w && (count_q < CNT_W'(ROB_SIZE));
   assign alloc_fire  = rob.alloc_valid && alloc_ready;
   assign head1       = head_q + IDX_W'(1);
   assign ret0        = !flush_w && valid_q[head_q] && complete_q[head_q];
   assign ret1        = ret0 && valid_q[head1] && complete_q[head1];
   assign n_ret       = RET_W'(ret0) + RET_W'(ret1);

   always_comb begin
      valid_d    = valid_q;
      complete_d = complete_q;
      head_d     = head_q + IDX_W'(n_ret);
      tail_d     = tail_q + IDX_W'(alloc_fire);
      count_d    = count_q + CNT_W'(alloc_fire) - CNT_W'(n_ret);
      for (int k = 0; k < NCMP; k++) begin
         if (cmp_vld[k] && valid_q[cmp_idx[k]]) complete_d[cmp_idx[k]] = 1'b1;
      end
      if (ret0) begin
         valid_d[head_q]    = 1'b0;
         complete_d[head_q] = 1'b0;
      end
      if (ret1) begin
         valid_d[head1]    = 1'b0;
         complete_d[head1] = 1'b0;
      end
      if (alloc_fire) begin
         valid_d[tail_q]    = 1'b1;
         complete_d[tail_q] = 1'b0;
      end
      if (flush_w) begin
         valid_d    = '0;
         complete_d = '0;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q    <= '0;
         complete_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
      end else begin
         valid_q    <= valid_d;
         complete_q <= complete_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
      end
   end

   // Payload is qualified by valid_q, so it needs no reset; the descending loop lets port 0 win.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         arch_rd_q[tail_q]     <= rob.alloc_arch_rd;
         phys_rd_q[tail_q]     <= rob.alloc_phys_rd;
         old_phys_rd_q[tail_q] <= rob.alloc_old_phys_rd;
         reg_write_q[tail_q]   <= rob.alloc_reg_write;
      end
      for (int k = NCMP - 1; k >= 0; k--) begin
         if (cmp_vld[k] && valid_q[cmp_idx[k]]) value_q[cmp_idx[k]] <= cmp_val[k];
      end
   end

   assign rob.alloc_ready          = alloc_ready;
   assign rob.alloc_rob_num        = tail_q;
   assign rob.rob_count            = count_q;

   assign rob.retire_valid_0       = ret0;
   assign rob.retire_arch_rd_0     = ret0 ? arch_rd_q[head_q]     : '0;
   assign rob.retire_phys_rd_0     = ret0 ? phys_rd_q[head_q]     : '0;
   assign rob.retire_old_phys_rd_0 = ret0 ? old_phys_rd_q[head_q] : '0;
   assign rob.retire_reg_write_0   = ret0 ? reg_write_q[head_q]   : 1'b0;
   assign rob.retire_value_0       = ret0 ? value_q[head_q]       : '0;

   assign rob.retire_valid_1       = ret1;
   assign rob.retire_arch_rd_1     = ret1 ? arch_rd_q[head1]      : '0;
   assign rob.retire_phys_rd_1     = ret1 ? phys_rd_q[head1]      : '0;
   assign rob.retire_old_phys_rd_1 = ret1 ? old_phys_rd_q[head1]  : '0;
   assign rob.retire_reg_write_1   = ret1 ? reg_write_q[head1]    : 1'b0;
   assign rob.retire_value_1       = ret1 ? value_q[head1]        : '0;
endmodule
